pointwise_conv: RTL and testbench

Runtime-reprogrammable 1×1 (pointwise) convolution layer for the fixed-point CNN pipeline. It maps IN_UNITS fixed-point channels to OUT_UNITS channels per pixel, with a pipelined MAC/adder tree and round-and-saturate output. Weights live in a double-buffered register file, and bank swaps happen only at a frame boundary. It sits between feature-extraction layers and the segmentation head, and carries the vcnt/hcnt coordinate stream with matched latency.

---
 rtl/pointwise_conv.sv | 173 +++++++++++++++++
 tb/tb_pointwise_conv.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pointwise_conv.sv
// 1x1 convolution: IN_UNITS -> OUT_UNITS channels per pixel, double-buffered weights, round/saturate/ReLU.
// Latency K+2 cycles (K = adder-tree depth); one pixel per cycle, never stalls, no backpressure.
module pointwise_conv #(
  parameter int W_HEIGHT     = 32,
  parameter int W_WIDTH      = 32,
  parameter int IN_UNITS     = 12,
  parameter int OUT_UNITS    = 4,
  parameter int IN_INT_BITW  = 5,
  parameter int OUT_INT_BITW = 5,
  parameter int W_INT_BITW   = 5,
  parameter int FRAC_BITW    = 8,
  parameter int RELU         = 1,
  localparam int V_BITW    = $clog2(W_HEIGHT),
  localparam int H_BITW    = $clog2(W_WIDTH),
  localparam int IN_FIXED  = IN_INT_BITW + FRAC_BITW,
  localparam int OUT_FIXED = OUT_INT_BITW + FRAC_BITW,
  localparam int W_FIXED   = W_INT_BITW + FRAC_BITW,
  localparam int NW        = OUT_UNITS * (IN_UNITS + 1),
  localparam int AW        = $clog2(NW)
) (
  input  logic                              clock,
  input  logic                              n_rst,
  input  logic                              in_enable,
  input  logic [0:IN_FIXED*IN_UNITS-1]      in_pixels,
  input  logic [V_BITW-1:0]                 in_vcnt,
  input  logic [H_BITW-1:0]                 in_hcnt,
  input  logic                              wr_en,
  input  logic [AW-1:0]                     wr_addr,
  input  logic [W_FIXED-1:0]                wr_data,
  input  logic                              swap_req,
  input  logic                              clr_sat,
  output logic                              out_enable,
  output logic [0:OUT_FIXED*OUT_UNITS-1]    out_pixels,
  output logic [V_BITW-1:0]                 out_vcnt,
  output logic [H_BITW-1:0]                 out_hcnt,
  output logic                              bank_sel,
  output logic                              swap_pending,
  output logic                              sat
);
  localparam int K     = $clog2(IN_UNITS + 1);
  localparam int NT    = 1 << K;
  localparam int L     = K + 2;
  localparam int ACC_W = IN_FIXED + W_FIXED + K + 1;

  typedef logic signed [W_FIXED-1:0] w_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  localparam acc_t HALF    = acc_t'(1) <<< (FRAC_BITW - 1);
  localparam acc_t OUT_MAX = acc_t'((64'sd1 <<< (OUT_FIXED - 1)) - 64'sd1);
  localparam acc_t OUT_MIN = acc_t'(-(64'sd1 <<< (OUT_FIXED - 1)));

  w_t   w_q    [2][NW];
  w_t   w_d    [2][NW];
  acc_t tree_q [OUT_UNITS][K+1][NT];
  acc_t tree_d [OUT_UNITS][K+1][NT];
  logic en_q [L];
  logic en_d [L];
  logic [V_BITW-1:0] vcnt_q [L];
  logic [V_BITW-1:0] vcnt_d [L];
  logic [H_BITW-1:0] hcnt_q [L];
  logic [H_BITW-1:0] hcnt_d [L];
  logic signed [OUT_FIXED-1:0] res_q [OUT_UNITS];
  logic signed [OUT_FIXED-1:0] res_d [OUT_UNITS];
  logic signed [IN_FIXED-1:0]  x_ch  [IN_UNITS];
  acc_t rsh    [OUT_UNITS];
  logic ch_sat [OUT_UNITS];
  logic bank_sel_q, bank_sel_d, swap_pending_q, swap_pending_d, sat_q, sat_d;
  logic commit, rd_bank, any_sat;

  // The committing pixel (0,0) already reads the bank being switched in.
  always_comb begin
    commit         = swap_pending_q && in_enable && (in_vcnt == '0) && (in_hcnt == '0);
    rd_bank        = bank_sel_q ^ commit;
    bank_sel_d     = rd_bank;
    swap_pending_d = commit ? 1'b0 : (swap_pending_q | swap_req);
  end

  always_comb begin
    w_d = w_q;
    if (wr_en && (int'(wr_addr) < NW)) w_d[~bank_sel_q][wr_addr] = wr_data;
  end

  always_comb begin
    for (int i = 0; i < IN_UNITS; i++) x_ch[i] = in_pixels[i*IN_FIXED +: IN_FIXED];
  end

  always_comb begin
    for (int o = 0; o < OUT_UNITS; o++)
      for (int k = 0; k <= K; k++)
        for (int j = 0; j < NT; j++) tree_d[o][k][j] = '0;
    for (int o = 0; o < OUT_UNITS; o++) begin
      for (int i = 0; i < IN_UNITS; i++)
        tree_d[o][0][i] = acc_t'(x_ch[i]) * acc_t'(w_q[rd_bank][o*(IN_UNITS+1)+i]);
      tree_d[o][0][IN_UNITS] = acc_t'(w_q[rd_bank][o*(IN_UNITS+1)+IN_UNITS]) <<< FRAC_BITW;
      for (int k = 1; k <= K; k++)
        for (int j = 0; j < (NT >> k); j++)
          tree_d[o][k][j] = tree_q[o][k-1][2*j] + tree_q[o][k-1][2*j+1];
    end
  end

  // Saturation is judged on the rounded value, before ReLU can hide it.
  always_comb begin
    any_sat = 1'b0;
    for (int o = 0; o < OUT_UNITS; o++) begin
      rsh[o]    = (tree_q[o][K][0] + HALF) >>> FRAC_BITW;
      ch_sat[o] = 1'b0;
      res_d[o]  = rsh[o][OUT_FIXED-1:0];
      if (rsh[o] > OUT_MAX) begin
        res_d[o]  = OUT_MAX[OUT_FIXED-1:0];
        ch_sat[o] = 1'b1;
      end else if (rsh[o] < OUT_MIN) begin
        res_d[o]  = OUT_MIN[OUT_FIXED-1:0];
        ch_sat[o] = 1'b1;
      end
      if ((RELU != 0) && res_d[o][OUT_FIXED-1]) res_d[o] = '0;
      any_sat = any_sat | ch_sat[o];
    end
  end

  always_comb begin
    en_d[0]   = in_enable;
    vcnt_d[0] = in_vcnt;
    hcnt_d[0] = in_hcnt;
    for (int i = 1; i < L; i++) begin
      en_d[i]   = en_q[i-1];
      vcnt_d[i] = vcnt_q[i-1];
      hcnt_d[i] = hcnt_q[i-1];
    end
    sat_d = (en_q[L-2] && any_sat) ? 1'b1 : (clr_sat ? 1'b0 : sat_q);
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      bank_sel_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      sat_q          <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < NW; a++) w_q[b][a] <= '0;
      for (int o = 0; o < OUT_UNITS; o++) begin
        res_q[o] <= '0;
        for (int k = 0; k <= K; k++)
          for (int j = 0; j < NT; j++) tree_q[o][k][j] <= '0;
      end
      for (int i = 0; i < L; i++) begin
        en_q[i]   <= 1'b0;
        vcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      bank_sel_q     <= bank_sel_d;
      swap_pending_q <= swap_pending_d;
      sat_q          <= sat_d;
      w_q            <= w_d;
      tree_q         <= tree_d;
      res_q          <= res_d;
      en_q           <= en_d;
      vcnt_q         <= vcnt_d;
      hcnt_q         <= hcnt_d;
    end
  end

  always_comb begin
    out_pixels = '0;
    for (int o = 0; o < OUT_UNITS; o++) out_pixels[o*OUT_FIXED +: OUT_FIXED] = res_q[o];
  end

  assign out_enable   = en_q[L-1];
  assign out_vcnt     = vcnt_q[L-1];
  assign out_hcnt     = hcnt_q[L-1];
  assign bank_sel     = bank_sel_q;
  assign swap_pending = swap_pending_q;
  assign sat          = sat_q;
endmodule

// File: tb/tb_pointwise_conv.sv
// Bench for pointwise_conv: arithmetic reference model over a per-cycle input history,
// two DUTs (RELU=1 and RELU=0) checked every cycle, plus literal spot checks.
module tb_pointwise_conv;
  localparam int IU = 12, OU = 4, F = 13, L = 6, NW = 52, MAXC = 4096;

  logic clock = 1'b0, n_rst = 1'b0;
  logic in_enable = 1'b0;
  logic [0:F*IU-1] in_pixels = '0;
  logic [4:0] in_vcnt = '0, in_hcnt = '0;
  logic wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [F-1:0] wr_data = '0;
  logic swap_req = 1'b0, clr_sat = 1'b0;

  logic out_enable, out_enable0, bank_sel, bank_sel0, swap_pending, swap_pending0, sat, sat0;
  logic [0:F*OU-1] out_pixels, out_pixels0;
  logic [4:0] out_vcnt, out_hcnt, out_vcnt0, out_hcnt0;

  pointwise_conv #(.RELU(1)) u_dut (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .clr_sat(clr_sat), .out_enable(out_enable), .out_pixels(out_pixels),
    .out_vcnt(out_vcnt), .out_hcnt(out_hcnt), .bank_sel(bank_sel),
    .swap_pending(swap_pending), .sat(sat));

  pointwise_conv #(.RELU(0)) u_dut0 (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .clr_sat(clr_sat), .out_enable(out_enable0), .out_pixels(out_pixels0),
    .out_vcnt(out_vcnt0), .out_hcnt(out_hcnt0), .bank_sel(bank_sel0),
    .swap_pending(swap_pending0), .sat(sat0));

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int wm [2][NW];
  int mbank = 0, mpend = 0, msat = 0, cyc = 0, last_rst = 0;
  bit mvalid = 1'b0;
  bit h_en [MAXC];
  bit h_s  [MAXC];
  int h_v  [MAXC];
  int h_h  [MAXC];
  int h_p1 [MAXC][OU];
  int h_p0 [MAXC][OU];
  bit e_en;
  int e_v, e_h;
  int e_p1 [OU];
  int e_p0 [OU];
  logic [F-1:0] tsl;
  int xs [IU];

  always @(posedge clock) begin
    int acc, r, eff, j, ci, jm;
    bit s, sany, commit;
    ci = cyc % MAXC;
    if (!n_rst) begin
      last_rst = cyc;
      mbank = 0; mpend = 0; msat = 0;
      for (int b = 0; b < 2; b++) for (int a = 0; a < NW; a++) wm[b][a] = 0;
      e_en = 0; e_v = 0; e_h = 0;
      for (int o = 0; o < OU; o++) begin e_p1[o] = 0; e_p0[o] = 0; end
    end else begin
      commit = (mpend != 0) && in_enable && (in_vcnt == 0) && (in_hcnt == 0);
      eff = commit ? 1 - mbank : mbank;
      for (int i = 0; i < IU; i++) begin
        tsl = in_pixels[i*F +: F];
        xs[i] = $signed(tsl);
      end
      sany = 0;
      for (int o = 0; o < OU; o++) begin
        acc = wm[eff][o*13+12] * 256;
        for (int i = 0; i < IU; i++) acc += xs[i] * wm[eff][o*13+i];
        r = (acc + 128) >>> 8;
        s = 0;
        if (r > 4095) begin r = 4095; s = 1; end
        else if (r < -4096) begin r = -4096; s = 1; end
        sany |= s;
        h_p0[ci][o] = r;
        h_p1[ci][o] = (r < 0) ? 0 : r;
      end
      h_en[ci] = in_enable; h_v[ci] = in_vcnt; h_h[ci] = in_hcnt; h_s[ci] = sany;
      if (wr_en && wr_addr < NW) wm[1-mbank][wr_addr] = $signed(wr_data);
      mbank = eff;
      mpend = commit ? 0 : ((mpend != 0 || swap_req) ? 1 : 0);
      j = cyc - (L - 1);
      if (j > last_rst) begin
        jm = j % MAXC;
        e_en = h_en[jm]; e_v = h_v[jm]; e_h = h_h[jm];
        for (int o = 0; o < OU; o++) begin e_p1[o] = h_p1[jm][o]; e_p0[o] = h_p0[jm][o]; end
        if (h_en[jm] && h_s[jm]) msat = 1;
        else if (clr_sat) msat = 0;
      end else begin
        e_en = 0; e_v = 0; e_h = 0;
        for (int o = 0; o < OU; o++) begin e_p1[o] = 0; e_p0[o] = 0; end
        if (clr_sat) msat = 0;
      end
    end
    cyc++;
    mvalid = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  logic [0:F*OU-1] v1, v0;
  always @(negedge clock) begin
    int t;
    bit xen;
    #1;
    if (mvalid) begin
      xen = n_rst ? e_en : 1'b0;
      for (int o = 0; o < OU; o++) begin
        t = n_rst ? e_p1[o] : 0; v1[o*F +: F] = t[F-1:0];
        t = n_rst ? e_p0[o] : 0; v0[o*F +: F] = t[F-1:0];
      end
      chk("out_enable", out_enable, xen);
      chk("out_enable_r0", out_enable0, xen);
      if (xen || !n_rst) begin
        chk("out_pixels", out_pixels, v1);
        chk("out_pixels_r0", out_pixels0, v0);
        chk("out_vcnt", out_vcnt, n_rst ? e_v : 0);
        chk("out_hcnt", out_hcnt, n_rst ? e_h : 0);
      end
      chk("bank_sel", bank_sel, n_rst ? mbank : 0);
      chk("swap_pending", swap_pending, n_rst ? mpend : 0);
      chk("sat", sat, n_rst ? msat : 0);
      chk("sat_r0", sat0, n_rst ? msat : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(negedge clock); endtask
  task automatic quiet();
    in_enable = 0; wr_en = 0; swap_req = 0; clr_sat = 0;
  endtask
  task automatic idle(input int n); quiet(); repeat (n) step(); endtask
  task automatic set_all(input logic [F-1:0] val);
    for (int i = 0; i < IU; i++) in_pixels[i*F +: F] = val;
  endtask
  task automatic set_rand();
    logic [F-1:0] r;
    for (int i = 0; i < IU; i++) begin r = F'($urandom); in_pixels[i*F +: F] = r; end
  endtask
  task automatic pix(input int v, input int h, input bit sw);
    quiet(); in_enable = 1; in_vcnt = v[4:0]; in_hcnt = h[4:0]; swap_req = sw; step();
    swap_req = 0;
  endtask
  task automatic wr(input int a, input int d);
    quiet(); wr_en = 1; wr_addr = a[5:0]; wr_data = d[F-1:0]; step(); wr_en = 0;
  endtask
  task automatic req_swap(); quiet(); swap_req = 1; step(); swap_req = 0; endtask

  initial begin
    int wd;
    set_all('0);
    repeat (3) step();
    chk("rst_out_enable", out_enable, 0);
    chk("rst_out_pixels", out_pixels, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_sat", sat, 0);
    chk("rst_vcnt", out_vcnt, 0);
    n_rst = 1; step();

    // identity through bank 1
    wr(0, 256);
    req_swap();
    chk("id_pending", swap_pending, 1);
    set_all('0); in_pixels[0 +: F] = 13'd768;
    pix(0, 0, 0);
    chk("id_bank_sel", bank_sel, 1);
    chk("id_pending_clr", swap_pending, 0);
    idle(5);
    chk("id_out_enable", out_enable, 1);
    chk("id_pixels", out_pixels, {13'd768, 39'd0});
    chk("id_pixels_r0", out_pixels0, {13'd768, 39'd0});
    chk("id_coords", {out_vcnt, out_hcnt}, 0);

    // saturation, rounding and negative bias through bank 0
    for (int i = 0; i < IU; i++) wr(i, 256);
    wr(25, -512);
    wr(26, 128);
    req_swap();
    set_all(13'd4095); pix(0, 0, 0);
    set_all(13'd1);    pix(0, 1, 0);
    set_all('0);       pix(0, 2, 0);
    idle(3);
    chk("sat_ch0_max", out_pixels[0 +: F], 13'h0FFF);
    chk("sat_flag", sat, 1);
    step();
    chk("round_ch0", out_pixels[0 +: F], 13'd12);
    chk("round_half_up", out_pixels[26 +: F], 13'd1);
    chk("sat_sticky", sat, 1);
    step();
    chk("relu_bias", out_pixels[13 +: F], 13'd0);
    chk("norelu_bias", out_pixels0[13 +: F], 13'h1E00);
    quiet(); clr_sat = 1; step(); clr_sat = 0;
    chk("clr_sat", sat, 0);

    // swap gating: armed at (3,5), committed only at (0,0)
    wr(44, 300);
    set_rand(); pix(3, 5, 1);
    chk("gate_pending", swap_pending, 1);
    chk("gate_bank_hold", bank_sel, 0);
    set_rand(); pix(1, 2, 0);
    set_rand(); pix(0, 3, 1);
    chk("gate_still_pending", swap_pending, 1);
    set_rand(); pix(0, 0, 0);
    chk("gate_bank_commit", bank_sel, 1);
    chk("gate_pending_clr", swap_pending, 0);
    idle(6);

    // randomized streaming with writes, swaps, sat clears and one mid-stream reset
    for (int c = 0; c < 1500; c++) begin
      set_rand();
      in_enable = ($urandom_range(0, 3) != 0);
      in_vcnt = 5'($urandom_range(0, 2));
      in_hcnt = 5'($urandom_range(0, 2));
      wr_en = ($urandom_range(0, 2) != 0);
      wr_addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) wd = int'($urandom_range(0, 8191));
      else wd = int'($urandom_range(0, 511)) - 256;
      wr_data = wd[F-1:0];
      swap_req = ($urandom_range(0, 15) == 0);
      clr_sat = ($urandom_range(0, 15) == 0);
      if (c == 700) begin
        n_rst = 0;
        #1;
        chk("mid_rst_enable", out_enable, 0);
        chk("mid_rst_pixels", out_pixels0, 0);
        chk("mid_rst_bank", bank_sel, 0);
        chk("mid_rst_sat", sat, 0);
        step(); step();
        n_rst = 1;
        quiet(); in_enable = 1; in_vcnt = 5'd1; in_hcnt = 5'd1;
        for (int k = 1; k <= L; k++) begin
          set_rand();
          step();
          if (k < L) chk("post_rst_no_enable", out_enable, 0);
          else begin
            chk("post_rst_first_enable", out_enable, 1);
            chk("post_rst_zero_weights", out_pixels0, 0);
          end
        end
      end else begin
        step();
      end
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
